// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with first-word fall-through output and registered handshakes.
// Define AXIS_PKT_FIFO_STORE_FWD_EN to hold output until a whole TLAST packet is stored.
module axis_pkt_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [CW-1:0]           level,
  output logic [CW-1:0]           pkts
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + SW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           wr, rd, pkt_in, pkt_out;
  logic [CW-1:0]  next_level, next_pkts;
  logic           next_valid;

  assign wr      = s_axis_tvalid && s_axis_tready && !areset;
  assign rd      = m_axis_tvalid && m_axis_tready;
  assign pkt_in  = wr && s_axis_tlast;
  assign pkt_out = rd && m_axis_tlast;

  assign {m_axis_tlast, m_axis_tstrb, m_axis_tdata} = mem[rd_ptr];

  always_comb begin
    next_level = level;
    next_pkts  = pkts;
    case ({wr, rd})
      2'b10:   next_level = level + CW'(1);
      2'b01:   next_level = level - CW'(1);
      default: next_level = level;
    endcase
    case ({pkt_in, pkt_out})
      2'b10:   next_pkts = pkts + CW'(1);
      2'b01:   next_pkts = pkts - CW'(1);
      default: next_pkts = pkts;
    endcase
  end

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  // Oversize-release: a full buffer with no complete packet can only drain
  // as a stream, otherwise upstream and downstream deadlock.
  logic ovr, next_ovr;

  always_comb begin
    next_ovr   = (ovr && !pkt_out) || (next_level == FULL && next_pkts == '0);
    next_valid = next_ovr ? (next_level != '0) : (next_pkts != '0);
  end

  always_ff @(posedge aclk) begin
    if (areset) ovr <= 1'b0;
    else        ovr <= next_ovr;
  end
`else
  assign next_valid = (next_level != '0);
`endif

  always_ff @(posedge aclk) begin
    if (wr) mem[wr_ptr] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      pkts          <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      level         <= next_level;
      pkts          <= next_pkts;
      m_axis_tvalid <= next_valid;
      s_axis_tready <= (next_level < FULL);
    end
  end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo (DEPTH=16); packet-mode scenarios run when
// AXIS_PKT_FIFO_STORE_FWD_EN is defined, stream-mode scenarios otherwise.
module tb_axis_pkt_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata;
  logic [3:0]    s_axis_tstrb;
  logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [3:0]    m_axis_tstrb;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [CW-1:0] level, pkts;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] src_d[$];
  bit            src_l[$];
  int            src_idx;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .level(level), .pkts(pkts)
  );

  always #5 aclk = ~aclk;

  function automatic logic [3:0] strb_of(input logic [DW-1:0] d);
    return ~d[3:0];
  endfunction

  task automatic load_src();
    if (src_idx < src_d.size()) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = src_d[src_idx];
      s_axis_tstrb  = strb_of(src_d[src_idx]);
      s_axis_tlast  = src_l[src_idx];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tstrb  = '0;
      s_axis_tlast  = 1'b0;
    end
  endtask

  task automatic clear_src();
    src_d.delete();
    src_l.delete();
    src_idx = 0;
    load_src();
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One clock: report the beat read at this edge, advance the source if accepted.
  task automatic step(output bit got, output logic [DW-1:0] d, output logic [3:0] st,
                      output logic l);
    bit acc;
    acc = s_axis_tvalid && s_axis_tready;
    got = m_axis_tvalid && m_axis_tready;
    d   = m_axis_tdata;
    st  = m_axis_tstrb;
    l   = m_axis_tlast;
    tick();
    if (acc) src_idx++;
    load_src();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'hDEAD_BEEF;
    s_axis_tstrb = 4'hF;
    s_axis_tlast = 1'b1;
    repeat (3) tick();
    n_chk++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid: got %b want 0", m_axis_tvalid); end
    n_chk++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_sready: got %b want 0", s_axis_tready); end
    n_chk++; if (level !== 0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", level); end
    n_chk++; if (pkts !== 0) begin n_fail++; $display("FAIL rst_pkts: got %0d want 0", pkts); end
    areset = 1'b0;
    clear_src();
    tick();
    n_chk++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_sready: got %b want 1", s_axis_tready); end
    n_chk++; if (level !== 0 || m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_release_empty: level %0d mvalid %b want 0/0", level, m_axis_tvalid); end
  endtask

  task automatic test_reset_mid();
    bit got; logic [DW-1:0] d; logic [3:0] st; logic l;
    clear_src();
    for (int i = 0; i < 3; i++) begin src_d.push_back(32'h55 + i); src_l.push_back(1'b1); end
    m_axis_tready = 1'b0;
    load_src();
    repeat (3) step(got, d, st, l);
    n_chk++; if (level !== 3) begin n_fail++; $display("FAIL mid_pre_level: got %0d want 3", level); end
    areset = 1'b1;
    clear_src();
    tick();
    n_chk++; if (level !== 0 || pkts !== 0 || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: level %0d pkts %0d mvalid %b sready %b want 0/0/0/0", level, pkts, m_axis_tvalid, s_axis_tready);
    end
    areset = 1'b0;
    tick();
    n_chk++; if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: sready %b mvalid %b want 1/0", s_axis_tready, m_axis_tvalid);
    end
  endtask

`ifndef AXIS_PKT_FIFO_STORE_FWD_EN
  task automatic test_fill_drain();
    bit got; logic [DW-1:0] d; logic [3:0] st; logic l;
    int exp, nrd;
    clear_src();
    for (int i = 1; i <= 17; i++) begin src_d.push_back(i); src_l.push_back(1'b0); end
    m_axis_tready = 1'b0;
    load_src();
    nrd = 0;
    repeat (16) begin step(got, d, st, l); if (got) nrd++; end
    n_chk++; if (level !== 16) begin n_fail++; $display("FAIL fill_level: got %0d want 16", level); end
    n_chk++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL fill_sready: got %b want 0", s_axis_tready); end
    n_chk++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL fill_mvalid: got %b want 1", m_axis_tvalid); end
    repeat (2) begin step(got, d, st, l); if (got) nrd++; end
    n_chk++; if (src_idx !== 16 || level !== 16 || nrd !== 0) begin
      n_fail++; $display("FAIL fill_hold17: accepted %0d level %0d reads %0d want 16/16/0", src_idx, level, nrd);
    end
    m_axis_tready = 1'b1;
    exp = 1;
    for (int c = 0; c < 60 && exp <= 17; c++) begin
      step(got, d, st, l);
      if (got) begin
        n_chk++; if (d !== exp || st !== strb_of(exp) || l !== 1'b0) begin
          n_fail++; $display("FAIL drain_beat: got %0d/%h/%b want %0d/%h/0", d, st, l, exp, strb_of(exp));
        end
        exp++;
      end
    end
    n_chk++; if (exp !== 18) begin n_fail++; $display("FAIL drain_count: got %0d beats want 17", exp - 1); end
    n_chk++; if (level !== 0 || m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: level %0d mvalid %b want 0/0", level, m_axis_tvalid);
    end
  endtask

  task automatic test_back_pressure();
    bit got; logic [DW-1:0] d; logic [3:0] st; logic l;
    int exp; bit seen1; bit bad_pkts;
    clear_src();
    for (int i = 1; i <= 20; i++) begin src_d.push_back(i); src_l.push_back(i == 20); end
    load_src();
    exp = 1; seen1 = 0; bad_pkts = 0;
    for (int c = 0; c < 400 && exp <= 20; c++) begin
      m_axis_tready = ($urandom_range(0, 1) == 1);
      step(got, d, st, l);
      if (got) begin
        n_chk++; if (d !== exp || st !== strb_of(exp) || l !== (exp == 20)) begin
          n_fail++; $display("FAIL bp_beat: got %0d/%h/%b want %0d/%h/%b", d, st, l, exp, strb_of(exp), exp == 20);
        end
        exp++;
      end
      if (pkts == 1) seen1 = 1;
      if (pkts > 1) bad_pkts = 1;
    end
    m_axis_tready = 1'b0;
    n_chk++; if (exp !== 21) begin n_fail++; $display("FAIL bp_count: got %0d beats want 20", exp - 1); end
    n_chk++; if (!seen1 || bad_pkts) begin n_fail++; $display("FAIL bp_pkts: saw1 %b saw>1 %b want 1/0", seen1, bad_pkts); end
    n_chk++; if (pkts !== 0 || level !== 0) begin n_fail++; $display("FAIL bp_end: pkts %0d level %0d want 0/0", pkts, level); end
  endtask

  task automatic test_simultaneous();
    bit got; logic [DW-1:0] d; logic [3:0] st; logic l;
    int exp;
    clear_src();
    for (int i = 0; i < 40; i++) begin src_d.push_back(32'hA000_0000 + i); src_l.push_back(1'b0); end
    m_axis_tready = 1'b0;
    load_src();
    repeat (8) step(got, d, st, l);
    n_chk++; if (level !== 8) begin n_fail++; $display("FAIL sim_pre_level: got %0d want 8", level); end
    m_axis_tready = 1'b1;
    step(got, d, st, l);
    n_chk++; if (level !== 8) begin n_fail++; $display("FAIL sim_level: got %0d want 8", level); end
    n_chk++; if (!got || d !== 32'hA000_0000) begin n_fail++; $display("FAIL sim_first: got %b/%h want 1/a0000000", got, d); end
    exp = 1;
    for (int c = 0; c < 100 && exp < 40; c++) begin
      step(got, d, st, l);
      if (got) begin
        n_chk++; if (d !== 32'hA000_0000 + exp) begin
          n_fail++; $display("FAIL wrap_beat: got %h want %h", d, 32'hA000_0000 + exp);
        end
        exp++;
      end
    end
    n_chk++; if (exp !== 40 || level !== 0) begin n_fail++; $display("FAIL wrap_end: beats %0d level %0d want 40/0", exp, level); end
  endtask
`else
  task automatic test_pkt_normal();
    bit got; logic [DW-1:0] d; logic [3:0] st; logic l;
    int exp, nrd;
    clear_src();
    for (int i = 1; i <= 5; i++) begin src_d.push_back(i); src_l.push_back(1'b0); end
    m_axis_tready = 1'b1;
    load_src();
    nrd = 0;
    repeat (7) begin step(got, d, st, l); if (got) nrd++; end
    n_chk++; if (m_axis_tvalid !== 1'b0 || nrd !== 0) begin n_fail++; $display("FAIL pkt_hold: mvalid %b reads %0d want 0/0", m_axis_tvalid, nrd); end
    n_chk++; if (level !== 5 || pkts !== 0) begin n_fail++; $display("FAIL pkt_hold_cnt: level %0d pkts %0d want 5/0", level, pkts); end
    src_d.push_back(6); src_l.push_back(1'b1);
    load_src();
    step(got, d, st, l);
    n_chk++; if (pkts !== 1 || m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL pkt_release: pkts %0d mvalid %b want 1/1", pkts, m_axis_tvalid); end
    exp = 1;
    for (int c = 0; c < 40 && exp <= 6; c++) begin
      step(got, d, st, l);
      if (got) begin
        n_chk++; if (d !== exp || st !== strb_of(exp) || l !== (exp == 6)) begin
          n_fail++; $display("FAIL pkt_beat: got %0d/%h/%b want %0d/%h/%b", d, st, l, exp, strb_of(exp), exp == 6);
        end
        exp++;
      end
    end
    n_chk++; if (exp !== 7 || level !== 0 || pkts !== 0) begin
      n_fail++; $display("FAIL pkt_end: beats %0d level %0d pkts %0d want 6/0/0", exp - 1, level, pkts);
    end
  endtask

  task automatic test_pkt_oversize();
    bit got; logic [DW-1:0] d; logic [3:0] st; logic l;
    int exp;
    clear_src();
    for (int i = 1; i <= 20; i++) begin src_d.push_back(i); src_l.push_back(i == 20); end
    m_axis_tready = 1'b0;
    load_src();
    repeat (15) step(got, d, st, l);
    n_chk++; if (m_axis_tvalid !== 1'b0 || level !== 15) begin n_fail++; $display("FAIL ovr_pre: mvalid %b level %0d want 0/15", m_axis_tvalid, level); end
    step(got, d, st, l);
    n_chk++; if (m_axis_tvalid !== 1'b1 || level !== 16 || pkts !== 0) begin
      n_fail++; $display("FAIL ovr_release: mvalid %b level %0d pkts %0d want 1/16/0", m_axis_tvalid, level, pkts);
    end
    m_axis_tready = 1'b1;
    exp = 1;
    for (int c = 0; c < 80 && exp <= 20; c++) begin
      step(got, d, st, l);
      if (got) begin
        n_chk++; if (d !== exp || l !== (exp == 20)) begin
          n_fail++; $display("FAIL ovr_beat: got %0d/%b want %0d/%b", d, l, exp, exp == 20);
        end
        exp++;
      end
    end
    n_chk++; if (exp !== 21 || level !== 0 || m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_end: beats %0d level %0d mvalid %b want 20/0/0", exp - 1, level, m_axis_tvalid);
    end
  endtask
`endif

  initial begin
    src_idx = 0;
    m_axis_tready = 1'b0;
    test_reset();
    test_reset_mid();
`ifndef AXIS_PKT_FIFO_STORE_FWD_EN
    test_fill_drain();
    test_back_pressure();
    test_simultaneous();
`else
    test_pkt_normal();
    test_pkt_oversize();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Parametrised AXI-Stream FIFO for the image datapath. It sits between pixel producers (DMA, sensor front-end) and processing IPs. It absorbs downstream back-pressure across a configurable depth and carries TDATA, TSTRB and TLAST without change. An optional packet (store-and-forward) mode holds output until a complete TLAST-terminated line or frame is buffered.

## Interface
- DATA_WIDTH, 32: TDATA width in bits; must be a multiple of 8.
- DEPTH, 16: number of storage entries; must be a power of two and at least 4.
- CW (local), $clog2(DEPTH)+1: width of the level and packet counters.

Ports:
- aclk  in  1  the single clock; all logic is rising-edge.
- areset  in  1  reset; synchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tstrb  in  DATA_WIDTH/8  input byte strobes; stored with the data.
- s_axis_tlast  in  1  end-of-packet marker.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  FIFO can accept a beat.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tstrb  out  DATA_WIDTH/8  output strobes.
- m_axis_tlast  out  1  output end-of-packet.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream accepts the beat.
- level  out  CW  number of stored entries, 0..DEPTH.
- pkts  out  CW  number of complete packets stored (stored TLAST=1 entries).

## Operation
- Storage: circular buffer of DEPTH entries of {tlast, tstrb, tdata}, with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
- Write: occurs when s_axis_tvalid && s_axis_tready. The entry goes to mem[wr_ptr] and wr_ptr increments.
- Read: occurs when m_axis_tvalid && m_axis_tready. rd_ptr increments.
- m_axis_tdata, m_axis_tstrb and m_axis_tlast always present mem[rd_ptr] (first-word fall-through). They are don't-care while m_axis_tvalid=0.
- Level update:
  - write only: level+1.
  - read only: level-1.
  - write and read in the same cycle: level unchanged.
- pkts update:
  - +1 on a write with tlast=1.
  - -1 on a read with m_axis_tlast=1.
  - both in the same cycle: unchanged.
- s_axis_tready is registered. Its next value is (next_level < DEPTH). It therefore drops the cycle after the beat that fills entry DEPTH.
- When full, a read in the same cycle does not allow a write that cycle. tready returns in the following cycle.
- m_axis_tvalid is registered as the next-state valid condition:
  - stream mode: next_level != 0.
  - packet mode: see Configuration.
- Order is preserved strictly. There is no drop, no duplicate and no reordering.
- The AXI-Stream rule applies: once m_axis_tvalid is high it stays high, with stable data, until a read occurs.

## Timing
- Reset (areset sampled high at a clock edge):
  - pointers, level and pkts clear to 0.
  - m_axis_tvalid = 0 and s_axis_tready = 0.
  - m_axis_tdata/tstrb/tlast are don't-care.
  - memory contents are not cleared.
- s_axis_tready rises in the first cycle after the edge at which areset is sampled low.
- Reset mid-operation discards all stored beats. Transfers presented during reset are ignored.
- Write-to-output latency is 1 cycle: a beat written into an empty FIFO at edge N produces m_axis_tvalid=1 after edge N (stream mode).
- Sustained throughput is 1 beat per cycle when neither side stalls.
- Full: s_axis_tready=0 while level=DEPTH.
- Empty: m_axis_tvalid=0 while level=0.
- Pointer wrap is transparent and has no bubble.

## Configuration
- Macro: AXIS_PKT_FIFO_STORE_FWD_EN.
- Without the macro (stream mode): m_axis_tvalid is high whenever level > 0. pkts is still maintained for status only.
- With the macro (packet mode):
  - m_axis_tvalid is high only when pkts > 0, or when the FIFO is in the oversize-release state.
  - Oversize-release:
    - set when level=DEPTH and pkts=0, which is a packet longer than DEPTH.
    - in this state the FIFO behaves as stream mode.
    - cleared on the read of a TLAST beat, or on reset.
  - This state prevents deadlock. Packets of DEPTH beats or fewer are never released partially.

## Test plan
- Reset: hold areset 3 cycles with s_axis_tvalid=1 -> m_axis_tvalid=0, s_axis_tready=0, level=0, nothing stored. s_axis_tready=1 in the first cycle after release.
- Fill/drain (DEPTH=16):
  - stimulus: m_axis_tready=0, push 1..17.
  - response while stalled: beats 1..16 accepted, s_axis_tready=0 after the 16th, level=16, beat 17 held.
  - response after m_axis_tready=1: output 1..17 in order, level returns to 0.
- Back-pressure: 20 beats 1..20, TLAST on 20, random 50% m_axis_tready -> output exactly 1..20, m_axis_tlast only on 20, pkts 1 then 0.
- Simultaneous: at level=8, one write and one read in the same cycle -> level stays 8. Output order is intact across a pointer wrap after 40 beats.
- Packet mode (macro on), normal packet:
  - send 5 beats without TLAST -> m_axis_tvalid stays 0, level=5, pkts=0.
  - send a 6th beat with TLAST -> pkts=1 and m_axis_tvalid=1 one cycle later; 6 beats delivered.
- Packet mode (macro on), oversize: 20-beat packet, DEPTH=16 -> at level=16 with pkts=0, m_axis_tvalid asserts; all 20 beats delivered in order, TLAST on 20.
